mul_sched: RTL and testbench
============================

MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter ADDR_W, default 12, width of A/B word addresses.
REQ-002 Parameter STEP_W, default 16, width of the compute-step count.
REQ-003 clk  input  1  the block's single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle request to begin one multiply pass.
REQ-006 cfg_mode  input  1  1 = A right-multiply (byte-serial A), 0 = B-broadcast mode; sampled at start.
REQ-007 cfg_steps  input  STEP_W  number of compute steps in the pass; sampled at start.
REQ-008 cfg_a_base, cfg_b_base  input  ADDR_W each  first A/B word addresses; sampled at start.
REQ-009 mac_ready  input  1  downstream MAC array accepts a step this cycle.
REQ-010 a_rd_en, b_rd_en  output  1 each  read strobes to A/B memories (1-cycle read latency).
REQ-011 a_addr, b_addr  output  ADDR_W each  read addresses, valid with the strobes.
REQ-012 start_pos  output  1  one-cycle pulse clearing the data-select offsets.
REQ-013 short_data_mode  output  1  registered copy of cfg_mode for the pass.
REQ-014 short_bia_add, long_bia_add  output  1 each  advance byte / halfword select offsets.
REQ-015 mul_valid  output  1  selected operands are valid for the MAC this cycle.
REQ-016 busy  output  1  high from start acceptance until done.
REQ-017 done  output  1  one-cycle pulse at end of pass.

Function
REQ-018 States: IDLE, PRIME, RUN, DONE; encoding free.
REQ-019 IDLE + start: latch config; if cfg_steps=0 go DONE, else go PRIME; start_pos=1 in the acceptance cycle.
REQ-020 start outside IDLE is ignored; config is not re-sampled.
REQ-021 PRIME (1 cycle): a_rd_en=b_rd_en=1, a_addr=cfg_a_base, b_addr=cfg_b_base; next RUN.
REQ-022 RUN with mac_ready=1 is a step: mul_valid=1, step counter +1.
REQ-023 RUN with mac_ready=0: mul_valid, both bia_add, both rd_en =0; all counters and addresses hold.
REQ-024 Mode 1 step: short_bia_add=1, long_bia_add=0; B word advances every step; A word advances every 8th step (byte index 7).
REQ-025 Mode 0 step: short_bia_add=1, long_bia_add=1; A word advances every 2nd step (half index 1); B word advances every 4th step (halfword index 3).
REQ-026 An advance is a read issued in the same step cycle: rd_en=1, addr=previous addr+1, so new data is present on the next step.
REQ-027 Byte/half/halfword sub-indices wrap 7->0, 1->0, 3->0; addresses wrap modulo 2^ADDR_W.
REQ-028 On the final step (counter = cfg_steps-1) no further reads are issued; next state DONE.
REQ-029 DONE (1 cycle): done=1, busy=0 afterwards; next IDLE; a start in DONE is ignored.
REQ-030 busy=1 in PRIME, RUN, DONE (the done cycle); 0 in IDLE.
REQ-031 short_data_mode holds its value after done until the next accepted start.
REQ-032 The A/B memories hold read data while rd_en=0 (environment requirement).

Reset
REQ-033 rstn low asynchronously forces IDLE, all counters and addresses to 0, every output to 0.
REQ-034 Reset mid-pass aborts with no done pulse; first accepted start after release starts a fresh pass.

Verification
REQ-035 Mode 1, steps=16, bases 0x010/0x100, mac_ready=1 -> A reads 0x010,0x011; B reads 0x100..0x10F; 16 mul_valid; done 1 cycle after last step.
REQ-036 Mode 0, steps=8, bases 0/0 -> A reads 0..3, B reads 0,1; long_bia_add and short_bia_add high on all 8 steps.
REQ-037 Mode 1, steps=8, mac_ready low for 3 cycles mid-pass -> no strobes or reads in stall cycles; total mul_valid count 8, done delayed by 3.
REQ-038 cfg_steps=0 -> start_pos then done next cycle; no rd_en or mul_valid.
REQ-039 start pulsed during RUN and DONE -> ignored; addresses/steps unchanged; single done.
REQ-040 rstn low at step 5 of 16 -> outputs 0 immediately, no done; new start runs full 16 steps from new bases.

Source files
------------

// File: rtl/mul_sched.sv
// Operand-fetch scheduler for one MAC pass: primes the A/B memories, then
// steps the byte/halfword select offsets and issues word reads as operands run out.
module mul_sched #(
    parameter int ADDR_W = 12,
    parameter int STEP_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              cfg_mode,
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic              mac_ready,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              start_pos,
    output logic              short_data_mode,
    output logic              short_bia_add,
    output logic              long_bia_add,
    output logic              mul_valid,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   steps_q;
    logic [STEP_W-1:0]   step_cnt_q;
    logic [ADDR_W-1:0]   a_addr_q;
    logic [ADDR_W-1:0]   b_addr_q;
    logic [2:0]          byte_idx_q;
    logic                half_idx_q;
    logic [1:0]          hw_idx_q;

    logic                accept;
    logic                step;
    logic                last_step;
    logic                a_adv;
    logic                b_adv;

    assign dbg_state       = state_q;
    assign last_step       = (step_cnt_q == steps_q - 1'b1);

    // Handshake: a step happens only in RUN while mac_ready is high; a stalled
    // RUN cycle changes nothing, so the memories keep presenting the same words.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        step          = 1'b0;
        a_adv         = 1'b0;
        b_adv         = 1'b0;
        a_rd_en       = 1'b0;
        b_rd_en       = 1'b0;
        a_addr        = a_addr_q;
        b_addr        = b_addr_q;
        start_pos     = 1'b0;
        short_bia_add = 1'b0;
        long_bia_add  = 1'b0;
        mul_valid     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    start_pos = 1'b1;
                    state_d   = (cfg_steps == '0) ? S_DONE : S_PRIME;
                end
            end

            S_PRIME: begin
                busy    = 1'b1;
                a_rd_en = 1'b1;
                b_rd_en = 1'b1;
                state_d = S_RUN;
            end

            S_RUN: begin
                busy = 1'b1;
                if (mac_ready) begin
                    step          = 1'b1;
                    mul_valid     = 1'b1;
                    short_bia_add = 1'b1;
                    long_bia_add  = ~short_data_mode;
                    if (last_step) begin
                        state_d = S_DONE;
                    end else if (short_data_mode) begin
                        // Byte-serial A: one A word covers eight steps, B is fresh each step.
                        a_adv = (byte_idx_q == 3'd7);
                        b_adv = 1'b1;
                    end else begin
                        a_adv = half_idx_q;
                        b_adv = (hw_idx_q == 2'd3);
                    end
                end
                a_rd_en = a_adv;
                b_rd_en = b_adv;
                if (a_adv) a_addr = a_addr_q + 1'b1;
                if (b_adv) b_addr = b_addr_q + 1'b1;
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            short_data_mode <= 1'b0;
            steps_q         <= '0;
            step_cnt_q      <= '0;
            a_addr_q        <= '0;
            b_addr_q        <= '0;
            byte_idx_q      <= '0;
            half_idx_q      <= 1'b0;
            hw_idx_q        <= '0;
        end else if (accept) begin
            short_data_mode <= cfg_mode;
            steps_q         <= cfg_steps;
            step_cnt_q      <= '0;
            a_addr_q        <= cfg_a_base;
            b_addr_q        <= cfg_b_base;
            byte_idx_q      <= '0;
            half_idx_q      <= 1'b0;
            hw_idx_q        <= '0;
        end else if (step) begin
            // Sub-indices wrap naturally at their widths (7->0, 1->0, 3->0).
            step_cnt_q <= step_cnt_q + 1'b1;
            byte_idx_q <= byte_idx_q + 1'b1;
            half_idx_q <= ~half_idx_q;
            hw_idx_q   <= hw_idx_q + 1'b1;
            if (a_adv) a_addr_q <= a_addr;
            if (b_adv) b_addr_q <= b_addr;
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// Randomized bench for mul_sched: a per-pass word-list and step-timing model
// predicts every strobe, address and pulse of each pass.
module tb_mul_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        cfg_mode;
    logic [15:0] cfg_steps;
    logic [11:0] cfg_a_base;
    logic [11:0] cfg_b_base;
    logic        mac_ready;
    logic        a_rd_en;
    logic        b_rd_en;
    logic [11:0] a_addr;
    logic [11:0] b_addr;
    logic        start_pos;
    logic        short_data_mode;
    logic        short_bia_add;
    logic        long_bia_add;
    logic        mul_valid;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [11:0] exp_a_q[$];
    logic [11:0] exp_b_q[$];

    mul_sched #(.ADDR_W(12), .STEP_W(16)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .cfg_mode        (cfg_mode),
        .cfg_steps       (cfg_steps),
        .cfg_a_base      (cfg_a_base),
        .cfg_b_base      (cfg_b_base),
        .mac_ready       (mac_ready),
        .a_rd_en         (a_rd_en),
        .b_rd_en         (b_rd_en),
        .a_addr          (a_addr),
        .b_addr          (b_addr),
        .start_pos       (start_pos),
        .short_data_mode (short_data_mode),
        .short_bia_add   (short_bia_add),
        .long_bia_add    (long_bia_add),
        .mul_valid       (mul_valid),
        .busy            (busy),
        .done            (done),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, {8'h0, a_addr, b_addr}, 32'h0);
        check({tag, "_ctl"}, {a_rd_en, b_rd_en, start_pos, short_data_mode,
                              short_bia_add, long_bia_add, mul_valid, busy, done}, 32'h0);
    endtask

    // One pass: accept, then model each cycle from the driven mac_ready.
    task automatic run_pass(input logic mode, input logic [15:0] steps,
                            input logic [11:0] a_base, input logic [11:0] b_base,
                            input int stall_pct, input int stall_at, input int stall_len,
                            input bit poke, input int abort_at);
        int  nsteps;
        int  k;
        int  done_cyc;
        int  stalled;
        int  nval;
        int  a_words;
        int  b_words;
        int  bound;
        bit  finished;
        logic mr, exp_step, exp_a, exp_b;
        logic [11:0] ea;

        nsteps = steps;
        exp_a_q.delete();
        exp_b_q.delete();
        if (nsteps == 0) begin
            a_words = 0;
            b_words = 0;
        end else if (mode) begin
            a_words = (nsteps + 7) / 8;
            b_words = nsteps;
        end else begin
            a_words = (nsteps + 1) / 2;
            b_words = (nsteps + 3) / 4;
        end
        for (int i = 0; i < a_words; i++) exp_a_q.push_back(a_base + 12'(i));
        for (int i = 0; i < b_words; i++) exp_b_q.push_back(b_base + 12'(i));

        @(negedge clk);
        start      = 1'b1;
        cfg_mode   = mode;
        cfg_steps  = steps;
        cfg_a_base = a_base;
        cfg_b_base = b_base;
        mac_ready  = 1'($urandom_range(1));
        #1;
        check("acc_start_pos", start_pos, 1'b1);
        check("acc_busy", busy, 1'b0);
        check("acc_rd", {a_rd_en, b_rd_en, mul_valid, done}, 4'b0);

        k        = 0;
        stalled  = 0;
        nval     = 0;
        finished = 0;
        done_cyc = (nsteps == 0) ? 1 : -1;
        bound    = 8 * nsteps + 64;
        for (int cyc = 1; cyc <= bound; cyc++) begin
            @(negedge clk);
            mr = ($urandom_range(99) >= stall_pct);
            if (cyc >= 2 && k == stall_at && stalled < stall_len) begin
                mr = 1'b0;
                stalled++;
            end
            mac_ready = mr;
            start     = poke ? 1'($urandom_range(1)) : 1'b0;
            if (poke) begin
                cfg_mode   = 1'($urandom_range(1));
                cfg_steps  = 16'($urandom_range(3));
                cfg_a_base = 12'($urandom_range(4095));
                cfg_b_base = 12'($urandom_range(4095));
            end
            if (abort_at >= 0 && cyc >= 2 && k == abort_at) begin
                rstn  = 1'b0;
                start = 1'b0;
                #1;
                check_all_zero("abort");
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk);
                    #1;
                    check("abort_done", {busy, done}, 2'b00);
                end
                rstn = 1'b1;
                return;
            end
            #1;
            exp_step = (nsteps != 0) && (cyc >= 2) && (k < nsteps) && mr;
            exp_a = 1'b0;
            exp_b = 1'b0;
            if (nsteps != 0 && cyc == 1) begin
                exp_a = 1'b1;
                exp_b = 1'b1;
            end else if (exp_step && k != nsteps - 1) begin
                exp_a = mode ? (k % 8 == 7) : (k % 2 == 1);
                exp_b = mode ? 1'b1 : (k % 4 == 3);
            end
            check("mul_valid", mul_valid, exp_step);
            check("short_bia", short_bia_add, exp_step);
            check("long_bia", long_bia_add, exp_step & ~mode);
            check("a_rd_en", a_rd_en, exp_a);
            check("b_rd_en", b_rd_en, exp_b);
            if (exp_a) begin
                ea = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 12'hxxx;
                check("a_addr", a_addr, ea);
            end
            if (exp_b) begin
                ea = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 12'hxxx;
                check("b_addr", b_addr, ea);
            end
            check("done", done, cyc == done_cyc);
            check("busy", busy, 1'b1);
            check("start_pos", start_pos, 1'b0);
            check("mode", short_data_mode, mode);
            if (mul_valid) nval++;
            if (exp_step) begin
                k++;
                if (k == nsteps) done_cyc = cyc + 1;
            end
            if (cyc == done_cyc) begin
                finished = 1;
                break;
            end
        end
        if (!finished) check("timeout", 0, 1);
        check("step_count", nval, nsteps);
        check("a_left", exp_a_q.size(), 0);
        check("b_left", exp_b_q.size(), 0);

        @(negedge clk);
        start     = 1'b0;
        mac_ready = 1'($urandom_range(1));
        #1;
        check("post_idle", {busy, done, mul_valid, a_rd_en, b_rd_en}, 5'b0);
        check("post_mode", short_data_mode, mode);
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        cfg_mode   = 1'b0;
        cfg_steps  = '0;
        cfg_a_base = '0;
        cfg_b_base = '0;
        mac_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rstn = 1'b1;

        // Byte-serial A: two A words, sixteen B words.
        run_pass(1'b1, 16'd16, 12'h010, 12'h100, 0, -1, 0, 1'b0, -1);
        // B-broadcast: A 0..3, B 0..1.
        run_pass(1'b0, 16'd8, 12'h000, 12'h000, 0, -1, 0, 1'b0, -1);
        // Three stall cycles after step 4.
        run_pass(1'b1, 16'd8, 12'h020, 12'h040, 0, 4, 3, 1'b0, -1);
        // Empty pass.
        run_pass(1'b1, 16'd0, 12'h055, 12'h066, 0, -1, 0, 1'b0, -1);
        // Starts and config churn during RUN/DONE are ignored.
        run_pass(1'b1, 16'd12, 12'h300, 12'h400, 20, -1, 0, 1'b1, -1);
        // Reset after five steps, then a fresh full pass.
        run_pass(1'b1, 16'd16, 12'h111, 12'h222, 0, -1, 0, 1'b0, 5);
        run_pass(1'b0, 16'd16, 12'h0a0, 12'h0b0, 0, -1, 0, 1'b0, -1);
        // Address wrap at the top of the space.
        run_pass(1'b1, 16'd20, 12'hffe, 12'hff8, 10, -1, 0, 1'b0, -1);
        run_pass(1'b0, 16'd13, 12'hfff, 12'hffe, 10, -1, 0, 1'b0, -1);

        for (int t = 0; t < 12; t++) begin
            run_pass(1'($urandom_range(1)), 16'($urandom_range(40)),
                     12'($urandom_range(4095)), 12'($urandom_range(4095)),
                     $urandom_range(40), -1, 0, 1'($urandom_range(1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
